uart_word_tx: RTL



---
 rtl/uart_word_tx_if.sv | 22 ++
 rtl/uart_word_tx.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/uart_word_tx_if.sv
// Word handshake between the RAM-readout sequencer (master) and the
// UART word transmitter (slave). The serial line itself is a plain port.
interface uart_word_tx_if;
    logic [15:0] word_in;
    logic        word_valid;
    logic        word_ready;
    logic        word_done;

    modport master (
        output word_in,
        output word_valid,
        input  word_ready,
        input  word_done
    );

    modport slave (
        input  word_in,
        input  word_valid,
        output word_ready,
        output word_done
    );
endinterface

// File: rtl/uart_word_tx.sv
// uart_word_tx: takes one 16-bit word per valid/ready handshake and shifts
// it out as a run of 8N1 UART characters on uart_tx (idle high).
// Build option UART_WORD_TX_HEX_EN: when defined, each word is sent as four
// uppercase ASCII hex digits (MS nibble first) followed by CR LF; when not
// defined, the two raw bytes are sent, high byte first.
// All outputs come straight from flops; the next values are computed from
// the next state so they line up with the state register.
module uart_word_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic          clk,
    input  logic          reset,
    uart_word_tx_if.slave bus,
    output logic          uart_tx
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

`ifdef UART_WORD_TX_HEX_EN
    localparam int N_CHARS = 6;
`else
    localparam int N_CHARS = 2;
`endif
    localparam int CIDX_W = $clog2(N_CHARS);
    localparam logic [CIDX_W-1:0] CHAR_LAST = CIDX_W'(N_CHARS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [BAUD_W-1:0]   baud_cnt;
    logic [2:0]          bit_idx;
    logic [2:0]          bit_nxt;
    logic [CIDX_W-1:0]   char_idx;
    logic [15:0]         word_q;
    logic [7:0]          char_byte;
    logic                baud_wrap;
    logic                last_char;
    logic                accept;
    logic                tx_nxt;
    logic                ready_nxt;
    logic                done_nxt;
    logic                tx_q;
    logic                ready_q;
    logic                done_q;

    assign baud_wrap = (baud_cnt == BAUD_LAST);
    assign last_char = (char_idx == CHAR_LAST);
    // Ready is only ever high in IDLE, so acceptance is simply valid in IDLE.
    assign accept    = (state == IDLE) && bus.word_valid;
    // Bit index as it will be after this edge; the output mux needs it so the
    // registered line changes on the same edge as the bit boundary.
    assign bit_nxt   = (state == DATA && baud_wrap) ? bit_idx + 3'd1 : bit_idx;

`ifdef UART_WORD_TX_HEX_EN
    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Select the character for the current index: four hex digits then CR LF.
    always_comb begin
        char_byte = 8'h0A;
        case (char_idx)
            3'd0:    char_byte = hex_ascii(word_q[15:12]);
            3'd1:    char_byte = hex_ascii(word_q[11:8]);
            3'd2:    char_byte = hex_ascii(word_q[7:4]);
            3'd3:    char_byte = hex_ascii(word_q[3:0]);
            3'd4:    char_byte = 8'h0D;
            default: char_byte = 8'h0A;
        endcase
    end
`else
    // Select the character for the current index: high byte then low byte.
    always_comb begin
        char_byte = char_idx[0] ? word_q[7:0] : word_q[15:8];
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; every bit-level transition waits for the baud wrap.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (bus.word_valid)              state_nxt = START;
            START: if (baud_wrap)                   state_nxt = DATA;
            DATA:  if (baud_wrap && bit_idx == 3'd7) state_nxt = STOP;
            STOP:  if (baud_wrap)                   state_nxt = last_char ? IDLE : START;
            default:                                state_nxt = IDLE;
        endcase
    end

    // Word latch, baud counter, bit index and character index.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_q   <= '0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            char_idx <= '0;
        end else if (accept) begin
            word_q   <= bus.word_in;
            baud_cnt <= '0;
            bit_idx  <= '0;
            char_idx <= '0;
        end else if (state != IDLE) begin
            baud_cnt <= baud_wrap ? '0 : baud_cnt + BAUD_W'(1);
            bit_idx  <= bit_nxt;
            if (state == STOP && baud_wrap)
                char_idx <= last_char ? '0 : char_idx + CIDX_W'(1);
        end
    end

    // Next values of the registered outputs, derived from the next state.
    always_comb begin
        tx_nxt    = 1'b1;
        ready_nxt = (state_nxt == IDLE);
        done_nxt  = (state == STOP) && baud_wrap && last_char;
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = char_byte[bit_nxt];
            default: tx_nxt = 1'b1;
        endcase
    end

    // Output registers; reset forces the line idle and the block ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            tx_q    <= tx_nxt;
            ready_q <= ready_nxt;
            done_q  <= done_nxt;
        end
    end

    assign uart_tx        = tx_q;
    assign bus.word_ready = ready_q;
    assign bus.word_done  = done_q;

endmodule
